lc3_kbd_dsp_mio: RTL and testbench

LC3_KBD_DSP_MIO -- requirements
Module: lc3_kbd_dsp_mio

---
 rtl/lc3_kbd_dsp_mio.sv | 128 ++++++++++++
 tb/tb_lc3_kbd_dsp_mio.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_kbd_dsp_mio.sv
// LC-3 memory-mapped keyboard/display I/O block: keyboard and display character FIFOs
// behind the KBSR/KBDR/DSR/DDR register map.
module lc3_kbd_dsp_mio #(
  parameter int unsigned KB_DEPTH  = 4,
  parameter int unsigned DSP_DEPTH = 4,
  parameter int unsigned CHAR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LD_char,
  input  logic [CHAR_W-1:0] I_char,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DATA_IN,
  output logic [15:0]       DATA_OUT,
  output logic [15:0]       DDR,
  output logic              WR_DDR,
  input  logic              DSP_ACK,
  output logic              KB_INT,
  output logic              DSP_INT
);

  localparam int unsigned KbAw  = $clog2(KB_DEPTH);
  localparam int unsigned DspAw = $clog2(DSP_DEPTH);

  localparam logic [KbAw:0]  KbOne  = 1;
  localparam logic [DspAw:0] DspOne = 1;

  localparam logic [15:0] KbsrAddr = 16'hFE00;
  localparam logic [15:0] KbdrAddr = 16'hFE02;
  localparam logic [15:0] DsrAddr  = 16'hFE04;
  localparam logic [15:0] DdrAddr  = 16'hFE06;

  logic [CHAR_W-1:0] kb_mem  [KB_DEPTH];
  logic [CHAR_W-1:0] dsp_mem [DSP_DEPTH];

  logic [KbAw:0]  kb_wr_q, kb_rd_q;
  logic [DspAw:0] dsp_wr_q, dsp_rd_q;
  logic           kie_q, die_q, ovr_q;

  logic        kb_empty, kb_full, dsp_empty, dsp_full;
  logic        bus_rd, bus_wr;
  logic        kb_pop, kb_push, kb_ovf;
  logic        dsp_pop, dsp_push;
  logic        kbsr_wr, dsr_wr;
  logic [15:0] kb_head, dsp_head;
  logic        unused_data;

  assign unused_data = ^DATA_IN;

  assign kb_empty  = (kb_wr_q == kb_rd_q);
  assign kb_full   = (kb_wr_q[KbAw] != kb_rd_q[KbAw]) &&
                     (kb_wr_q[KbAw-1:0] == kb_rd_q[KbAw-1:0]);
  assign dsp_empty = (dsp_wr_q == dsp_rd_q);
  assign dsp_full  = (dsp_wr_q[DspAw] != dsp_rd_q[DspAw]) &&
                     (dsp_wr_q[DspAw-1:0] == dsp_rd_q[DspAw-1:0]);

  // Gating bus strobes with reset keeps DATA_OUT at zero and blocks pops while held in reset.
  assign bus_rd = reset & MIO_EN & ~R_W;
  assign bus_wr = reset & MIO_EN & R_W;

  assign kbsr_wr = bus_wr & (ADDR == KbsrAddr);
  assign dsr_wr  = bus_wr & (ADDR == DsrAddr);

  // A same-cycle pop frees the slot, so a push into a full FIFO still succeeds.
  assign kb_pop  = bus_rd & (ADDR == KbdrAddr) & ~kb_empty;
  assign kb_push = LD_char & (~kb_full | kb_pop);
  assign kb_ovf  = LD_char & kb_full & ~kb_pop;

  assign dsp_pop  = WR_DDR & DSP_ACK;
  assign dsp_push = bus_wr & (ADDR == DdrAddr) & (~dsp_full | dsp_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kb_wr_q  <= '0;
      kb_rd_q  <= '0;
      dsp_wr_q <= '0;
      dsp_rd_q <= '0;
      kie_q    <= 1'b0;
      die_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (kb_push)  kb_wr_q  <= kb_wr_q + KbOne;
      if (kb_pop)   kb_rd_q  <= kb_rd_q + KbOne;
      if (dsp_push) dsp_wr_q <= dsp_wr_q + DspOne;
      if (dsp_pop)  dsp_rd_q <= dsp_rd_q + DspOne;
      if (kbsr_wr)  kie_q    <= DATA_IN[14];
      if (dsr_wr)   die_q    <= DATA_IN[14];
      if (kb_ovf) begin
        ovr_q <= 1'b1;
      end else if (kbsr_wr && !DATA_IN[13]) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: emptiness is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (kb_push)  kb_mem[kb_wr_q[KbAw-1:0]]    <= I_char;
    if (dsp_push) dsp_mem[dsp_wr_q[DspAw-1:0]] <= DATA_IN[CHAR_W-1:0];
  end

  always_comb begin
    kb_head  = '0;
    dsp_head = '0;
    kb_head[CHAR_W-1:0]  = kb_mem[kb_rd_q[KbAw-1:0]];
    dsp_head[CHAR_W-1:0] = dsp_mem[dsp_rd_q[DspAw-1:0]];
  end

  always_comb begin
    DATA_OUT = '0;
    if (bus_rd) begin
      case (ADDR)
        KbsrAddr: DATA_OUT = {~kb_empty, kie_q, ovr_q, 13'b0};
        KbdrAddr: DATA_OUT = kb_empty ? 16'h0000 : kb_head;
        DsrAddr:  DATA_OUT = {~dsp_full, die_q, 14'b0};
        default:  DATA_OUT = '0;
      endcase
    end
  end

  assign WR_DDR  = ~dsp_empty;
  assign DDR     = dsp_empty ? 16'h0000 : dsp_head;
  assign KB_INT  = kie_q & ~kb_empty;
  assign DSP_INT = die_q & ~dsp_full;

endmodule

// File: tb/tb_lc3_kbd_dsp_mio.sv
// Scoreboard bench for lc3_kbd_dsp_mio: directed register-map sequences plus random traffic
// checked against a queue-based model of both character FIFOs.
module tb_lc3_kbd_dsp_mio;

  localparam int unsigned KbDepth  = 4;
  localparam int unsigned DspDepth = 4;

  logic        clk;
  logic        reset;
  logic        LD_char;
  logic [7:0]  I_char;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] ADDR;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic [15:0] DDR;
  logic        WR_DDR;
  logic        DSP_ACK;
  logic        KB_INT;
  logic        DSP_INT;

  lc3_kbd_dsp_mio #(
    .KB_DEPTH (KbDepth),
    .DSP_DEPTH(DspDepth),
    .CHAR_W   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .LD_char (LD_char),
    .I_char  (I_char),
    .MIO_EN  (MIO_EN),
    .R_W     (R_W),
    .ADDR    (ADDR),
    .DATA_IN (DATA_IN),
    .DATA_OUT(DATA_OUT),
    .DDR     (DDR),
    .WR_DDR  (WR_DDR),
    .DSP_ACK (DSP_ACK),
    .KB_INT  (KB_INT),
    .DSP_INT (DSP_INT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        ki;
    logic        di;
    logic [15:0] ddr;
  } st_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        mon_en = 1'b0;

  st_t         st_q[$];
  logic [15:0] sb_rd[$];
  logic [7:0]  sb_dsp[$];

  logic [7:0]  m_kb[$];
  logic [7:0]  m_dsp[$];
  logic        m_kie, m_die, m_ovr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kb.delete();
    m_dsp.delete();
    st_q.delete();
    sb_rd.delete();
    sb_dsp.delete();
    m_kie = 1'b0;
    m_die = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Drive one bus cycle, record what the DUT must show during it, then advance the model.
  task automatic cycle(input logic ld, input logic [7:0] ch, input logic en, input logic rw,
                       input logic [15:0] a, input logic [15:0] d, input logic ack);
    st_t         s;
    logic [15:0] rd;
    bit          kpop, dpop;
    @(posedge clk);
    #2;
    LD_char = ld;
    I_char  = ch;
    MIO_EN  = en;
    R_W     = rw;
    ADDR    = a;
    DATA_IN = d;
    DSP_ACK = ack;

    s.wr  = (m_dsp.size() != 0);
    s.ddr = s.wr ? {8'h00, m_dsp[0]} : 16'h0000;
    s.ki  = m_kie && (m_kb.size() != 0);
    s.di  = m_die && (m_dsp.size() < DspDepth);
    st_q.push_back(s);

    if (en && !rw) begin
      rd = 16'h0000;
      case (a)
        16'hFE00: rd = {(m_kb.size() != 0), m_kie, m_ovr, 13'b0};
        16'hFE02: rd = (m_kb.size() != 0) ? {8'h00, m_kb[0]} : 16'h0000;
        16'hFE04: rd = {(m_dsp.size() < DspDepth), m_die, 14'b0};
        default:  rd = 16'h0000;
      endcase
      sb_rd.push_back(rd);
    end

    kpop = en && !rw && (a == 16'hFE02) && (m_kb.size() != 0);
    dpop = (m_dsp.size() != 0) && ack;

    if (en && rw && a == 16'hFE00) begin
      m_kie = d[14];
      if (!d[13]) m_ovr = 1'b0;
    end
    if (en && rw && a == 16'hFE04) m_die = d[14];

    if (kpop) void'(m_kb.pop_front());
    if (ld) begin
      if (m_kb.size() < KbDepth) m_kb.push_back(ch);
      else m_ovr = 1'b1;
    end

    if (dpop) void'(m_dsp.pop_front());
    if (en && rw && a == 16'hFE06 && m_dsp.size() < DspDepth) begin
      m_dsp.push_back(d[7:0]);
      sb_dsp.push_back(d[7:0]);
    end
    mon_en = 1'b1;
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, ack);
  endtask

  task automatic rd_reg(input logic [15:0] a);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a, 16'h0000, 1'b0);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d, input logic ack);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, a, d, ack);
  endtask

  always @(negedge clk) begin
    st_t         s;
    logic [15:0] e;
    logic [7:0]  c;
    if (mon_en) begin
      if (st_q.size() == 0) begin
        chk("status_queue_underflow", 16'h0001, 16'h0000);
      end else begin
        s = st_q.pop_front();
        chk("WR_DDR", {15'b0, WR_DDR}, {15'b0, s.wr});
        chk("KB_INT", {15'b0, KB_INT}, {15'b0, s.ki});
        chk("DSP_INT", {15'b0, DSP_INT}, {15'b0, s.di});
        chk("DDR_hold", DDR, s.ddr);
      end
      if (MIO_EN && !R_W) begin
        if (sb_rd.size() == 0) begin
          chk("read_queue_underflow", DATA_OUT, 16'hxxxx);
        end else begin
          e = sb_rd.pop_front();
          chk("DATA_OUT", DATA_OUT, e);
        end
      end
      if (WR_DDR && DSP_ACK) begin
        if (sb_dsp.size() == 0) begin
          chk("unexpected_display_pop", DDR, 16'hxxxx);
        end else begin
          c = sb_dsp.pop_front();
          chk("DDR_pop", DDR, {8'h00, c});
        end
      end
    end
  end

  initial begin
    logic [15:0] a, d;
    reset   = 1'b0;
    LD_char = 1'b0;
    I_char  = 8'h00;
    MIO_EN  = 1'b1;
    R_W     = 1'b0;
    ADDR    = 16'hFE04;
    DATA_IN = 16'h0000;
    DSP_ACK = 1'b1;
    model_reset();

    #12;
    chk("reset_DATA_OUT", DATA_OUT, 16'h0000);
    chk("reset_DDR", DDR, 16'h0000);
    chk("reset_WR_DDR", {15'b0, WR_DDR}, 16'h0000);
    chk("reset_KB_INT", {15'b0, KB_INT}, 16'h0000);
    chk("reset_DSP_INT", {15'b0, DSP_INT}, 16'h0000);
    @(posedge clk);
    #2;
    MIO_EN = 1'b0;
    DSP_ACK = 1'b0;
    reset  = 1'b1;

    // Single keyboard character round trip
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    rd_reg(16'hFE00);
    rd_reg(16'hFE02);
    rd_reg(16'hFE00);

    // Keyboard overflow
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rd_reg(16'hFE00);
    for (int i = 0; i < 4; i++) rd_reg(16'hFE02);
    wr_reg(16'hFE00, 16'h0000, 1'b0);
    rd_reg(16'hFE00);
    rd_reg(16'hFE02);

    // Keyboard interrupt
    wr_reg(16'hFE00, 16'h4000, 1'b0);
    cycle(1'b1, 8'h31, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(1'b0);
    rd_reg(16'hFE02);
    idle(1'b0);
    wr_reg(16'hFE00, 16'h0000, 1'b0);

    // Display backpressure, then drain
    for (int i = 0; i < 5; i++) wr_reg(16'hFE06, 16'h0048 + 16'(i), 1'b0);
    rd_reg(16'hFE04);
    wr_reg(16'hFE04, 16'h4000, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Write into full display FIFO in the same cycle as a pop
    for (int i = 0; i < 4; i++) wr_reg(16'hFE06, 16'h0050 + 16'(i), 1'b0);
    wr_reg(16'hFE06, 16'h005A, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: a = 16'hFE00;
        1: a = 16'hFE02;
        2: a = 16'hFE04;
        3: a = 16'hFE06;
        default: a = 16'($urandom);
      endcase
      d = 16'($urandom);
      cycle(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), a, d, 1'($urandom));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    @(negedge clk);
    #1;
    chk("display_drained", 16'(sb_dsp.size()), 16'h0000);

    // Asynchronous reset with characters queued on both sides
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'h61 + 8'(i), 1'b1, 1'b1, 16'hFE06, 16'h0070 + 16'(i), 1'b0);
    @(posedge clk);
    #2;
    mon_en  = 1'b0;
    LD_char = 1'b0;
    MIO_EN  = 1'b1;
    R_W     = 1'b0;
    ADDR    = 16'hFE00;
    DSP_ACK = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("async_WR_DDR", {15'b0, WR_DDR}, 16'h0000);
    chk("async_KBSR", DATA_OUT, 16'h0000);
    chk("async_DDR", DDR, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    rd_reg(16'hFE00);
    idle(1'b1);
    rd_reg(16'hFE02);
    rd_reg(16'hFE04);
    for (int i = 0; i < 3; i++) idle(1'b1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
